// File: rtl/read_buffer_pkg.sv
// Shared definitions for the read buffer: word-count/select-width helpers
// and the controller state encoding.
package read_buffer_pkg;

    // Number of user words in one cache line.
    function automatic int unsigned words_f(input int unsigned cache_width,
                                            input int unsigned data_width);
        return cache_width / data_width;
    endfunction

    // Width of the word-select field inside a user word address.
    function automatic int unsigned wsel_f(input int unsigned cache_width,
                                           input int unsigned data_width);
        return $clog2(words_f(cache_width, data_width));
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/read_line_store.sv
// Single cache-line store: line data, line tag and valid bit, with a
// combinational hit compare and word select.
//   load/load_line/load_data : capture a returned line (sets valid)
//   inval                    : clear valid (a same-cycle load wins)
//   lookup_line/word_sel     : address being looked up
//   hit_c/word_c             : combinational hit flag and selected word
module read_line_store
    import read_buffer_pkg::*;
#(
    parameter int unsigned LINE_W      = 20,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   inval,
    input  logic [LINE_W-1:0]      load_line,
    input  logic [CACHE_WIDTH-1:0] load_data,
    input  logic [LINE_W-1:0]      lookup_line,
    input  logic [wsel_f(CACHE_WIDTH, DATA_WIDTH)-1:0] word_sel,
    output logic                   hit_c,
    output logic [DATA_WIDTH-1:0]  word_c
);

    logic [CACHE_WIDTH-1:0] line_q;
    logic [LINE_W-1:0]      tag_q;
    logic                   valid_q;

    // Line storage; a fill takes priority over an invalidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            line_q  <= load_data;
            tag_q   <= load_line;
            valid_q <= 1'b1;
        end else if (inval) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_c  = valid_q && (tag_q == lookup_line);
    assign word_c = line_q[32'(word_sel) * DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/read_buffer.sv
// Word-granular read front end for the AFU read channel. Holds one cache
// line; a hit returns the word next cycle, a miss issues one line read and
// returns the word the cycle after the matching response.
//   rd_req_*    : line read request (registered single-cycle strobe)
//   rd_rsp_*    : line read response, matched on issued tag
//   start       : invalidates the held line
//   usr_rd_*    : user word request/response (ready only in IDLE)
module read_buffer
    import read_buffer_pkg::*;
#(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_LMT-1:0]    rd_req_addr,
    output logic [MDATA-1:0]       rd_req_mdata,
    output logic                   rd_req_en,
    input  logic                   rd_req_almostfull,
    input  logic                   rd_rsp_valid,
    input  logic [MDATA-1:0]       rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
    input  logic                   start,
    input  logic                   usr_rd_en,
    input  logic [ADDR_LMT+wsel_f(CACHE_WIDTH, DATA_WIDTH)-1:0] usr_rd_addr,
    input  logic [MDATA-1:0]       usr_rd_mdata,
    output logic                   usr_rd_ready,
    output logic                   usr_rd_valid,
    output logic [DATA_WIDTH-1:0]  usr_rd_data,
    output logic [MDATA-1:0]       usr_rd_rsp_mdata
);

    localparam int unsigned WSEL    = wsel_f(CACHE_WIDTH, DATA_WIDTH);
    localparam int unsigned UADDR_W = ADDR_LMT + WSEL;

    state_t                state_q, state_d;
    logic [UADDR_W-1:0]    addr_q, addr_d;
    logic [MDATA-1:0]      umdata_q, umdata_d;
    logic [MDATA-1:0]      tag_cnt_q, tag_cnt_d;
    logic [MDATA-1:0]      issued_q, issued_d;

    logic [ADDR_LMT-1:0]   rd_req_addr_d;
    logic [MDATA-1:0]      rd_req_mdata_d;
    logic                  rd_req_en_d;
    logic                  usr_rd_ready_d;
    logic                  usr_rd_valid_d;
    logic [DATA_WIDTH-1:0] usr_rd_data_d;
    logic [MDATA-1:0]      usr_rd_rsp_mdata_d;

    logic                  fill_c;
    logic                  hit_c;
    logic [DATA_WIDTH-1:0] hit_word_c;
    logic [DATA_WIDTH-1:0] fill_word_c;

    logic [ADDR_LMT-1:0]   usr_line_c;
    logic [WSEL-1:0]       usr_word_c;
    logic [ADDR_LMT-1:0]   req_line_c;
    logic [WSEL-1:0]       req_word_c;

    assign usr_line_c = usr_rd_addr[UADDR_W-1:WSEL];
    assign usr_word_c = usr_rd_addr[WSEL-1:0];
    assign req_line_c = addr_q[UADDR_W-1:WSEL];
    assign req_word_c = addr_q[WSEL-1:0];

    // Word returned on a fill comes straight from the response line.
    assign fill_word_c = rd_rsp_data[32'(req_word_c) * DATA_WIDTH +: DATA_WIDTH];

    read_line_store #(
        .LINE_W      (ADDR_LMT),
        .CACHE_WIDTH (CACHE_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .load        (fill_c),
        .inval       (start),
        .load_line   (req_line_c),
        .load_data   (rd_rsp_data),
        .lookup_line (usr_line_c),
        .word_sel    (usr_word_c),
        .hit_c       (hit_c),
        .word_c      (hit_word_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            umdata_q         <= '0;
            tag_cnt_q        <= '0;
            issued_q         <= '0;
            rd_req_addr      <= '0;
            rd_req_mdata     <= '0;
            rd_req_en        <= 1'b0;
            usr_rd_ready     <= 1'b1;
            usr_rd_valid     <= 1'b0;
            usr_rd_data      <= '0;
            usr_rd_rsp_mdata <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            umdata_q         <= umdata_d;
            tag_cnt_q        <= tag_cnt_d;
            issued_q         <= issued_d;
            rd_req_addr      <= rd_req_addr_d;
            rd_req_mdata     <= rd_req_mdata_d;
            rd_req_en        <= rd_req_en_d;
            usr_rd_ready     <= usr_rd_ready_d;
            usr_rd_valid     <= usr_rd_valid_d;
            usr_rd_data      <= usr_rd_data_d;
            usr_rd_rsp_mdata <= usr_rd_rsp_mdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        umdata_d           = umdata_q;
        tag_cnt_d          = tag_cnt_q;
        issued_d           = issued_q;
        rd_req_addr_d      = rd_req_addr;
        rd_req_mdata_d     = rd_req_mdata;
        rd_req_en_d        = 1'b0;
        usr_rd_valid_d     = 1'b0;
        usr_rd_data_d      = usr_rd_data;
        usr_rd_rsp_mdata_d = usr_rd_rsp_mdata;
        fill_c             = 1'b0;

        case (state_q)
            IDLE: begin
                if (usr_rd_en) begin
                    addr_d   = usr_rd_addr;
                    umdata_d = usr_rd_mdata;
                    if (hit_c) begin
                        usr_rd_valid_d     = 1'b1;
                        usr_rd_data_d      = hit_word_c;
                        usr_rd_rsp_mdata_d = usr_rd_mdata;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (!rd_req_almostfull) begin
                    rd_req_en_d    = 1'b1;
                    rd_req_addr_d  = req_line_c;
                    rd_req_mdata_d = tag_cnt_q;
                    issued_d       = tag_cnt_q;
                    tag_cnt_d      = tag_cnt_q + MDATA'(1);
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                // Only the response carrying the issued tag completes the miss.
                if (rd_rsp_valid && (rd_rsp_mdata == issued_q)) begin
                    fill_c             = 1'b1;
                    usr_rd_valid_d     = 1'b1;
                    usr_rd_data_d      = fill_word_c;
                    usr_rd_rsp_mdata_d = umdata_q;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        usr_rd_ready_d = (state_d == IDLE);
    end

endmodule
